dct_dot8: RTL and testbench
===========================

Name: dct_dot8

Overview:
- Downstream consumer of the 64x24 DCT coefficient ROM.
- Computes one 8-point DCT dot product, result = sum over k=0..7 of sample[k] * C(row,k).
- Fetches the 8 coefficients of a selected row from the ROM. Coefficients use the 24-bit {16-bit signed mantissa Q1.15, 8-bit signed exponent} float format.
- Produces a rounded, saturated signed fixed-point result with a done pulse. Feeds the row/column transpose stage.

Parameters:
SW, 8, sample width (signed two's complement)
OUT_W, 16, result width (signed integer)
ACC_W, 40, accumulator width, 15 fractional bits
EXP_MAX, 8, largest left shift applied; larger positive exponents clamp to this

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
start  in  1  request; accepted only when busy=0
row  in  3  coefficient row u, latched on accepted start
samples  in  8*SW  sample k at bits [SW*k+SW-1:SW*k], latched on accepted start
rom_add  out  6  ROM address {row,k}
rom_rd  out  1  ROM read enable
rom_data  in  24  ROM output, valid the cycle after rom_rd
busy  out  1  operation in progress
done  out  1  one-cycle pulse, result valid
result  out  OUT_W  signed result, held until next done
ovf  out  1  saturation occurred in last result, held with result

Behaviour:
- Reset values: rom_rd=0, rom_add=0, busy=0, done=0, result=0, ovf=0, accumulator=0, state IDLE.
- FSM states:
  - IDLE: on start&!busy, latch row and samples, clear accumulator, k=0, go to FETCH.
  - FETCH: 8 cycles. rom_rd=1, rom_add={row,k}, k increments 0..7. After k=7 go to DRAIN.
  - DRAIN: 1 cycle. rom_rd=0; accumulates the last coefficient. Go to DONE.
  - DONE: 1 cycle. done=1; result and ovf registered. Go to IDLE.
- Timing, with T0 the start cycle:
  - T1..T8: reads issued.
  - T2..T9: rom_data present; accumulate on each of those edges.
  - T10: done=1.
- Latency start to done is 10 cycles. busy=1 during T1..T10.
- A start during busy (including the DONE cycle) is ignored, not queued. Back-to-back: the next start is accepted at T11.
- Decode: {ma,ea}=rom_data; ma signed 16, ea signed 8.
- Product p = sample * ma, a signed SW+16 product, sign-extended to ACC_W.
- Exponent shift:
  - ea >= 0: p << min(ea, EXP_MAX).
  - ea < 0: arithmetic right shift by min(-ea, 23), floor semantics.
- Accumulator: acc += shifted p; sized so no internal overflow is possible.
- Output conversion: r = acc >>> 15 (see Optional Feature for rounding).
- Saturation: if r > 2^(OUT_W-1)-1, result = max and ovf=1. If r < -2^(OUT_W-1), result = min and ovf=1. Otherwise result = r and ovf=0.
- rst asserted mid-operation: next cycle IDLE, all outputs at reset values, no done pulse.
- samples and row may change after the start cycle without effect.

Optional Feature:
- Macro DCT_DOT8_ROUND_EN.
- Defined: before the shift, add 2^14 to acc (round half up), then r = (acc+2^14)>>>15.
- Undefined: r = acc>>>15 (truncate toward -infinity).
- Saturation and timing are identical in both builds.

Test Plan:
- Row 0: all coefficients ma=0x4000, ea=0x00 (0.5); all samples=10; start -> done at T10, result=40, ovf=0; rom_add 0..7 on T1..T8.
- Row 3: coefficients ma=0x4000, ea=0x01 (1.0); samples 1..8 -> result=36. Row 5: ma=0x4000, ea=0xFE (0.125); samples all 8 -> result=8.
- Row 7: ma=0x7FFF, ea=0x08; samples all 127 -> result=32767, ovf=1. Same coefficients, samples all -128 -> result=-32768, ovf=1.
- Rounding on row 1, with coef k=0 = 0.5 and all others 0:
  - sample0=3: ROUND_EN build -> result=2; truncating build -> 1.
  - sample0=-3: ROUND_EN build -> -1; truncating build -> -2.
- start re-asserted at T5 and at T10 -> ignored (single done). start at T11 accepted, done at T21. rst at T6 -> busy=0, rom_rd=0, result=0 at T7, no done.

Source files
------------

// File: rtl/dct_dot8.sv
`default_nettype none
// ============================================================================
// Module      : dct_dot8
// Description : One 8-point DCT dot product. Fetches the 8 coefficients of a
//               row from the 64x24 coefficient ROM ({Q1.15 mantissa, signed
//               exponent}), multiply-accumulates against latched samples and
//               emits a saturated signed result with a one-cycle done pulse.
//               Optional macro DCT_DOT8_ROUND_EN selects round-half-up output
//               conversion instead of truncation toward -infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_dot8 #(
    parameter int SW      = 8,
    parameter int OUT_W   = 16,
    parameter int ACC_W   = 40,
    parameter int EXP_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              row,
    input  logic [8*SW-1:0]         samples,
    output logic [5:0]              rom_add,
    output logic                    rom_rd,
    input  logic [23:0]             rom_data,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] result,
    output logic                    ovf
);

    // State encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [7:0]              c_exp_max = 8'(EXP_MAX);
    localparam logic [8:0]              c_rsh_max = 9'd23;
    localparam logic signed [ACC_W-1:0] c_out_max = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_out_min = ACC_W'(-(2 ** (OUT_W - 1)));
`ifdef DCT_DOT8_ROUND_EN
    localparam logic signed [ACC_W-1:0] c_half    = ACC_W'(2 ** 14);
`endif

    logic [1:0]              r_state;
    logic [2:0]              r_row;
    logic [8*SW-1:0]         r_samples;
    logic [2:0]              r_k;
    logic [2:0]              r_kd;
    logic                    r_rd_d;
    logic signed [ACC_W-1:0] r_acc;

    logic signed [SW-1:0]    w_sample;
    logic signed [15:0]      w_ma;
    logic [7:0]              w_ea;
    logic signed [SW+15:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic [8:0]              w_neg_ea;
    logic [7:0]              w_lsh;
    logic [8:0]              w_rsh;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_acc_rnd;
    logic signed [ACC_W-1:0] w_r;

    // Decode the returning coefficient, scale the product and form the next accumulator / output value
    always_comb begin
        w_ma       = $signed(rom_data[23:8]);
        w_ea       = rom_data[7:0];
        // r_kd tracks which sample the ROM word now on rom_data belongs to
        w_sample   = r_samples[r_kd*SW +: SW];
        w_prod     = w_sample * w_ma;
        w_prod_ext = {{(ACC_W-SW-16){w_prod[SW+15]}}, w_prod};
        // Magnitude of a negative exponent; 9 bits so that -128 negates cleanly
        w_neg_ea   = 9'd0 - {w_ea[7], w_ea};
        w_lsh      = (w_ea > c_exp_max) ? c_exp_max : w_ea;
        w_rsh      = (w_neg_ea > c_rsh_max) ? c_rsh_max : w_neg_ea;
        w_shifted  = w_ea[7] ? (w_prod_ext >>> w_rsh) : (w_prod_ext <<< w_lsh);
        w_acc_next = r_rd_d ? (r_acc + w_shifted) : r_acc;
`ifdef DCT_DOT8_ROUND_EN
        w_acc_rnd  = w_acc_next + c_half;
`else
        w_acc_rnd  = w_acc_next;
`endif
        w_r        = w_acc_rnd >>> 15;
    end

    // Control FSM with registered ROM interface, accumulator and result/saturation outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_row     <= 3'd0;
            r_samples <= '0;
            r_k       <= 3'd0;
            r_kd      <= 3'd0;
            r_rd_d    <= 1'b0;
            r_acc     <= '0;
            rom_add   <= 6'd0;
            rom_rd    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
        end else begin
            // ROM data lags the read by one cycle, so delay the read strobe and index with it
            r_rd_d <= rom_rd;
            r_kd   <= r_k;
            r_acc  <= w_acc_next;
            done   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_row     <= row;
                        r_samples <= samples;
                        r_acc     <= '0;
                        r_k       <= 3'd0;
                        rom_add   <= {row, 3'd0};
                        rom_rd    <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (r_k == 3'd7) begin
                        rom_rd  <= 1'b0;
                        r_state <= c_DRAIN;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        rom_add <= {r_row, r_k + 3'd1};
                    end
                end
                c_DRAIN: begin
                    // The final coefficient is folded in here, so convert from the next-accumulator value
                    done <= 1'b1;
                    if (w_r > c_out_max) begin
                        result <= c_out_max[OUT_W-1:0];
                        ovf    <= 1'b1;
                    end else if (w_r < c_out_min) begin
                        result <= c_out_min[OUT_W-1:0];
                        ovf    <= 1'b1;
                    end else begin
                        result <= w_r[OUT_W-1:0];
                        ovf    <= 1'b0;
                    end
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_dot8.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_dot8
// Description : Directed self-checking bench for dct_dot8 with a behavioural
//               one-cycle-latency coefficient ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_dot8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2:0]         row;
    logic [63:0]        samples;
    logic [5:0]         rom_add;
    logic               rom_rd;
    logic [23:0]        rom_data;
    logic               busy;
    logic               done;
    logic signed [15:0] result;
    logic               ovf;

    logic [23:0] rom [64];
    int n_checks = 0;
    int n_errors = 0;

    dct_dot8 u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .row      (row),
        .samples  (samples),
        .rom_add  (rom_add),
        .rom_rd   (rom_rd),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Coefficient ROM: data valid the cycle after the read
    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom[rom_add];
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One operation; inputs are scrambled after T0 to show they are latched
    task automatic run_op(input string tag, input logic [2:0] r, input logic [63:0] s,
                          input logic signed [15:0] er, input logic eo);
        int done_t;
        done_t = -1;
        @(posedge clk); #1;
        row = r; samples = s; start = 1'b1;
        for (int t = 1; t <= 14 && done_t < 0; t++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            row     = 3'($urandom);
            samples = {$urandom, $urandom};
            if (t == 1) begin
                check({tag, "_busy_t1"}, busy, 1);
                check({tag, "_add_t1"}, {rom_rd, rom_add}, {1'b1, r, 3'd0});
            end
            if (t == 8) check({tag, "_add_t8"}, {rom_rd, rom_add}, {1'b1, r, 3'd7});
            if (done) done_t = t;
        end
        check({tag, "_latency"}, done_t, 10);
        check({tag, "_result"}, result, er);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        int n_done, first_t, last_t;
        for (int i = 0; i < 64; i++) rom[i] = 24'h0;
        for (int k = 0; k < 8; k++) begin
            rom[{3'd0, 3'(k)}] = {16'h4000, 8'h00};
            rom[{3'd3, 3'(k)}] = {16'h4000, 8'h01};
            rom[{3'd5, 3'(k)}] = {16'h4000, 8'hFE};
            rom[{3'd7, 3'(k)}] = {16'h7FFF, 8'h08};
        end
        rom[{3'd1, 3'd0}] = {16'h4000, 8'h00};
        rom_data = 24'h0;

        rst = 1'b1; start = 1'b0; row = 3'd0; samples = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {rom_rd, busy, done, ovf, rom_add}, 10'd0);
        check("rst_result", result, 0);
        rst = 1'b0;

        run_op("row0",   3'd0, 64'h0A0A0A0A0A0A0A0A,   40, 1'b0);
        run_op("row3",   3'd3, 64'h0807060504030201,   36, 1'b0);
        run_op("row5",   3'd5, 64'h0808080808080808,    8, 1'b0);
        run_op("satpos", 3'd7, 64'h7F7F7F7F7F7F7F7F, 32767, 1'b1);
        run_op("satneg", 3'd7, 64'h8080808080808080, -32768, 1'b1);
`ifdef DCT_DOT8_ROUND_EN
        run_op("rnd_p3", 3'd1, 64'h0000000000000003,    2, 1'b0);
        run_op("rnd_m3", 3'd1, 64'h00000000000000FD,   -1, 1'b0);
`else
        run_op("rnd_p3", 3'd1, 64'h0000000000000003,    1, 1'b0);
        run_op("rnd_m3", 3'd1, 64'h00000000000000FD,   -2, 1'b0);
`endif

        // Starts at T5 and T10 ignored; start at T11 accepted, done at T21
        n_done = 0; first_t = -1; last_t = -1;
        @(posedge clk); #1;
        row = 3'd3; samples = 64'h0807060504030201; start = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            @(posedge clk); #1;
            start = (t == 5 || t == 10 || t == 11);
            if (done) begin
                n_done++;
                if (first_t < 0) first_t = t;
                last_t = t;
            end
        end
        start = 1'b0;
        check("ign_ndone", n_done, 2);
        check("ign_first", first_t, 10);
        check("b2b_second", last_t, 21);
        check("b2b_result", result, 36);

        // Reset at T6 aborts the operation
        @(posedge clk); #1;
        row = 3'd0; samples = 64'h0A0A0A0A0A0A0A0A; start = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (t == 6) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_ctrl", {busy, rom_rd, done, ovf, rom_add}, 10'd0);
        check("mid_rst_result", result, 0);
        n_done = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("mid_rst_nodone", n_done, 0);

        run_op("after_rst", 3'd0, 64'h0A0A0A0A0A0A0A0A, 40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
